mem_arbiter: RTL and testbench

Sequencer and two-port arbiter in front of the pipeline's single-port word-addressed data memory. Shares the memory between the instruction-fetch port (`i_*`) and the load/store port (`d_*`), serialises accesses, and drives the memory's `addr`/`wdata`/`wmem`/`rmem` strobes for a fixed LAT-cycle access window. Returns registered read data with a one-cycle valid pulse, so the fetch and MEM stages can stall on `*_gnt`/`*_rvalid`.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch and load/store ports, the arbiter and the single-port data memory.
// The slave modport is the arbiter side. The master modport is the requesters plus the memory model.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_wmem;
    logic        m_rmem;
    logic [31:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_addr, m_wdata, m_wmem, m_rmem
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_addr, m_wdata, m_wmem, m_rmem
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port memory: grant at T, LAT access cycles, rvalid at T+LAT+1; losers hold req.
// MEM_ARB_RR_EN selects round-robin tie-breaking (default: data port always wins ties).
module mem_arbiter #(
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, wdata_q, ird_q, drd_q;
    logic          we_q, own_d_q;
    logic          slot, i_win, d_win, xfer, last;

    assign slot = (state_q == IDLE) || (state_q == RESP);
    assign xfer = i_win | d_win;
    assign last = (state_q == ACCESS) && (cnt_q == '0);

`ifdef MEM_ARB_RR_EN
    // Set when the data port owns the next tie; flips to the other side on every transfer.
    logic prio_d_q;

    always_comb begin
        d_win = slot & bus.d_req & (~bus.i_req | prio_d_q);
        i_win = slot & bus.i_req & (~bus.d_req | ~prio_d_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_d_q <= 1'b1;
        end else if (xfer) begin
            prio_d_q <= i_win;
        end
    end
`else
    always_comb begin
        d_win = slot & bus.d_req;
        i_win = slot & bus.i_req & ~bus.d_req;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (xfer) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = xfer ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
        if (xfer) begin
            cnt_d = CW'(LAT - 1);
        end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        bus.i_gnt    = i_win;
        bus.d_gnt    = d_win;
        bus.m_rmem   = (state_q == ACCESS) & ~we_q;
        // Stores strobe only on the closing access cycle so each one writes exactly once.
        bus.m_wmem   = last & we_q;
        bus.i_rvalid = (state_q == RESP) & ~own_d_q;
        bus.d_rvalid = (state_q == RESP) & own_d_q;
        bus.m_addr   = addr_q;
        bus.m_wdata  = wdata_q;
        bus.i_rdata  = ird_q;
        bus.d_rdata  = drd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            own_d_q <= 1'b0;
            ird_q   <= '0;
            drd_q   <= '0;
        end else begin
            if (xfer) begin
                addr_q  <= d_win ? bus.d_addr : bus.i_addr;
                wdata_q <= d_win ? bus.d_wdata : wdata_q;
                we_q    <= d_win & bus.d_we;
                own_d_q <= d_win;
            end
            if (last && !we_q) begin
                if (own_d_q) drd_q <= bus.m_rdata;
                else         ird_q <= bus.m_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (LAT=2) with a 64-word memory model on the m_* side.
module tb_mem_arbiter;
    logic clk;
    logic rst_n;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    int   wr_cnt   = 0;
    int   rd_cyc   = 0;
    logic [31:0] mem [0:63];

    mem_arbiter_if bus ();

    mem_arbiter #(.LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.m_rdata = mem[bus.m_addr[7:2]];

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'hC0DE_0000 + 32'(k);
        mem[4] = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            if (bus.m_wmem) begin
                mem[bus.m_addr[7:2]] = bus.m_wdata;
                wr_cnt++;
            end
            if (bus.m_rmem) rd_cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic apply_reset();
        step();
        rst_n = 1'b0;
        idle_bus();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_bus();
        @(negedge clk);
        tot_cnt++;
        if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.m_wmem, bus.m_rmem} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.m_wmem, bus.m_rmem});
        else pass_cnt++;
        tot_cnt++;
        if ({bus.m_addr, bus.m_wdata} !== 64'h0)
            $display("FAIL reset_maddr_wdata: got %h want 0", {bus.m_addr, bus.m_wdata});
        else pass_cnt++;
        tot_cnt++;
        if ({bus.i_rdata, bus.d_rdata} !== 64'h0)
            $display("FAIL reset_rdata: got %h want 0", {bus.i_rdata, bus.d_rdata});
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load();
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
        @(negedge clk);
        tot_cnt++;
        if ({bus.i_gnt, bus.d_gnt} !== 2'b01) $display("FAIL load_gnt: got %b want 01", {bus.i_gnt, bus.d_gnt});
        else pass_cnt++;
        step();
        bus.d_req = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if ({bus.m_rmem, bus.m_wmem, bus.m_addr} !== {2'b10, 32'h10})
            $display("FAIL load_t1: got %b %h want 10 00000010", {bus.m_rmem, bus.m_wmem}, bus.m_addr);
        else pass_cnt++;
        step();
        @(negedge clk);
        tot_cnt++;
        if ({bus.m_rmem, bus.m_wmem, bus.d_rvalid} !== 3'b100)
            $display("FAIL load_t2: got %b want 100", {bus.m_rmem, bus.m_wmem, bus.d_rvalid});
        else pass_cnt++;
        step();
        @(negedge clk);
        tot_cnt++;
        if ({bus.d_rvalid, bus.i_rvalid, bus.m_rmem} !== 3'b100)
            $display("FAIL load_t3_vld: got %b want 100", {bus.d_rvalid, bus.i_rvalid, bus.m_rmem});
        else pass_cnt++;
        tot_cnt++;
        if (bus.d_rdata !== 32'hDEADBEEF) $display("FAIL load_t3_data: got %h want deadbeef", bus.d_rdata);
        else pass_cnt++;
        step();
        @(negedge clk);
        tot_cnt++;
        if ({bus.d_rvalid, bus.m_addr} !== {1'b0, 32'h10})
            $display("FAIL load_t4_hold: got %b %h want 0 00000010", bus.d_rvalid, bus.m_addr);
        else pass_cnt++;
    endtask

    task automatic test_store();
        int w0;
        w0 = wr_cnt;
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678;
        @(negedge clk);
        tot_cnt++;
        if (bus.d_gnt !== 1'b1) $display("FAIL store_gnt: got %b want 1", bus.d_gnt);
        else pass_cnt++;
        step();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if ({bus.m_wmem, bus.m_rmem} !== 2'b00) $display("FAIL store_t1: got %b want 00", {bus.m_wmem, bus.m_rmem});
        else pass_cnt++;
        step();
        @(negedge clk);
        tot_cnt++;
        if ({bus.m_wmem, bus.m_rmem, bus.m_addr, bus.m_wdata} !== {2'b10, 32'h20, 32'h12345678})
            $display("FAIL store_t2: got %b %h %h want 10 00000020 12345678", {bus.m_wmem, bus.m_rmem}, bus.m_addr, bus.m_wdata);
        else pass_cnt++;
        step();
        @(negedge clk);
        tot_cnt++;
        if ({bus.d_rvalid, bus.m_wmem, bus.d_rdata} !== {2'b10, 32'hDEADBEEF})
            $display("FAIL store_t3: got %b %h want 10 deadbeef", {bus.d_rvalid, bus.m_wmem}, bus.d_rdata);
        else pass_cnt++;
        tot_cnt++;
        if (wr_cnt - w0 !== 1) $display("FAIL store_wr_count: got %0d want 1", wr_cnt - w0);
        else pass_cnt++;
        step();
        bus.d_req = 1'b1; bus.d_addr = 32'h20;
        @(negedge clk);
        tot_cnt++;
        if (bus.d_gnt !== 1'b1) $display("FAIL store_rd_gnt: got %b want 1", bus.d_gnt);
        else pass_cnt++;
        step();
        bus.d_req = 1'b0;
        step();
        step();
        @(negedge clk);
        tot_cnt++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h12345678})
            $display("FAIL store_readback: got %b %h want 1 12345678", bus.d_rvalid, bus.d_rdata);
        else pass_cnt++;
    endtask

    task automatic test_tie();
        logic [11:0] ig, dg;
        apply_reset();
        step();
        bus.i_req = 1'b1; bus.i_addr = 32'h0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h30;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ig[c] = bus.i_gnt;
            dg[c] = bus.d_gnt;
            if (c < 11) step();
        end
        step();
        idle_bus();
        repeat (3) step();
`ifdef MEM_ARB_RR_EN
        tot_cnt++;
        if (dg !== 12'h041) $display("FAIL tie_d_gnt: got %h want 041", dg);
        else pass_cnt++;
        tot_cnt++;
        if (ig !== 12'h208) $display("FAIL tie_i_gnt: got %h want 208", ig);
        else pass_cnt++;
`else
        tot_cnt++;
        if (dg !== 12'h249) $display("FAIL tie_d_gnt: got %h want 249", dg);
        else pass_cnt++;
        tot_cnt++;
        if (ig !== 12'h000) $display("FAIL tie_i_gnt: got %h want 000", ig);
        else pass_cnt++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [12:0] ig, rv;
        int k, nr, r0;
        k = 0; nr = 0; r0 = rd_cyc;
        step();
        bus.i_req = 1'b1; bus.i_addr = 32'h0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            ig[c] = bus.i_gnt;
            rv[c] = bus.i_rvalid;
            if (bus.i_gnt) k++;
            if (bus.i_rvalid) begin
                tot_cnt++;
                if (bus.i_rdata !== 32'hC0DE_0000 + 32'(nr))
                    $display("FAIL b2b_data%0d: got %h want %h", nr, bus.i_rdata, 32'hC0DE_0000 + 32'(nr));
                else pass_cnt++;
                nr++;
            end
            if (c < 12) begin
                step();
                bus.i_addr = 32'(k * 4);
                bus.i_req  = (k < 4);
            end
        end
        step();
        idle_bus();
        tot_cnt++;
        if (ig !== 13'h0249) $display("FAIL b2b_gnt: got %h want 0249", ig);
        else pass_cnt++;
        tot_cnt++;
        if (rv !== 13'h1248) $display("FAIL b2b_rvalid: got %h want 1248", rv);
        else pass_cnt++;
        tot_cnt++;
        if (rd_cyc - r0 !== 8) $display("FAIL b2b_rd_cycles: got %0d want 8", rd_cyc - r0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_store();
        int w0;
        logic [31:0] orig;
        logic seen;
        w0 = wr_cnt; orig = mem[16]; seen = 1'b0;
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        tot_cnt++;
        if (bus.d_gnt !== 1'b1) $display("FAIL rst_mid_gnt: got %b want 1", bus.d_gnt);
        else pass_cnt++;
        step();
        rst_n = 1'b0;
        idle_bus();
        @(negedge clk);
        tot_cnt++;
        if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.m_wmem, bus.m_rmem,
             bus.m_addr, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== 134'h0)
            $display("FAIL rst_mid_outputs: got %b %h %h want all 0",
                     {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.m_wmem, bus.m_rmem},
                     {bus.m_addr, bus.m_wdata}, {bus.i_rdata, bus.d_rdata});
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.i_rvalid || bus.d_rvalid || bus.m_wmem || bus.m_rmem) seen = 1'b1;
            step();
        end
        tot_cnt++;
        if (seen !== 1'b0) $display("FAIL rst_mid_quiet: got %b want 0", seen);
        else pass_cnt++;
        tot_cnt++;
        if ({wr_cnt - w0, mem[16]} !== {32'd0, orig})
            $display("FAIL rst_mid_mem: got %0d %h want 0 %h", wr_cnt - w0, mem[16], orig);
        else pass_cnt++;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        @(negedge clk);
        tot_cnt++;
        if (bus.d_gnt !== 1'b1) $display("FAIL rst_mid_idle_gnt: got %b want 1", bus.d_gnt);
        else pass_cnt++;
        step();
        bus.d_req = 1'b0;
        step();
        step();
        @(negedge clk);
        tot_cnt++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, orig})
            $display("FAIL rst_mid_readback: got %b %h want 1 %h", bus.d_rvalid, bus.d_rdata, orig);
        else pass_cnt++;
    endtask

    task automatic test_withdrawn();
        int r0, irv, drv;
        r0 = rd_cyc; irv = 0; drv = 0;
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
        @(negedge clk);
        tot_cnt++;
        if (bus.d_gnt !== 1'b1) $display("FAIL wd_d_gnt: got %b want 1", bus.d_gnt);
        else pass_cnt++;
        step();
        bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'h4;
        @(negedge clk);
        tot_cnt++;
        if (bus.i_gnt !== 1'b0) $display("FAIL wd_i_gnt: got %b want 0", bus.i_gnt);
        else pass_cnt++;
        step();
        bus.i_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.i_rvalid) irv++;
            if (bus.d_rvalid) drv++;
            step();
        end
        tot_cnt++;
        if ({irv, drv} !== {32'd0, 32'd1}) $display("FAIL wd_rvalid: got i=%0d d=%0d want i=0 d=1", irv, drv);
        else pass_cnt++;
        tot_cnt++;
        if (rd_cyc - r0 !== 2) $display("FAIL wd_rd_cycles: got %0d want 2", rd_cyc - r0);
        else pass_cnt++;
        tot_cnt++;
        if (bus.d_rdata !== 32'hDEADBEEF) $display("FAIL wd_d_rdata: got %h want deadbeef", bus.d_rdata);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_tie();
        test_back_to_back();
        test_reset_mid_store();
        test_withdrawn();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
